bm_buf_release: RTL and testbench
=================================

// Module: bm_buf_release
// PURPOSE
//  Walks the buffer link list of a departed or dropped packet and returns each buffer to the free
//  pool, one pointer per rel_buf_valid pulse, into the rel_buf_valid/rel_buf_ptr input of the
//  free buffer control. Requests give head and tail pointers. Next pointers come from link memory.
//  Requests are queued in a small FIFO; one chain is walked at a time.
// PARAMETERS
//  PTR_NBITS   `BUF_PTR_NBITS  buffer pointer width
//  LL_RD_LAT   2               link-memory read latency, cycles from ll_rd to ll_rd_data valid (>=1)
//  REQ_DEPTH   4               release request FIFO depth, power of 2
// PORTS
//  clk               in   1            clock
//  `RESET_SIG        in   1            synchronous, active-high reset
//  freeb_init_done   in   1            free pool initialised; low = pool in (re)init
//  rel_req_valid     in   1            release request, accepted when rel_req_ready=1
//  rel_req_head_ptr  in   PTR_NBITS    first buffer of chain
//  rel_req_tail_ptr  in   PTR_NBITS    last buffer of chain (== head for 1-buffer packet)
//  rel_req_ready     out  1            request FIFO not full and freeb_init_done
//  ll_rd             out  1            link-memory read strobe
//  ll_rd_ptr         out  PTR_NBITS    link-memory read address
//  ll_rd_data        in   PTR_NBITS    next pointer, valid exactly LL_RD_LAT cycles after ll_rd
//  rel_buf_valid     out  1            buffer released (to free buffer control)
//  rel_buf_ptr       out  PTR_NBITS    released buffer pointer
//  rel_done          out  1            1-cycle pulse: chain finished at tail
//  rel_done_count    out  PTR_NBITS+1  buffers released in finished chain, valid with rel_done/rel_err
//  rel_err           out  1            1-cycle pulse: chain aborted, 2**PTR_NBITS buffers w/o tail
//  busy              out  1            FSM not IDLE or request FIFO non-empty
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; request FIFO empty; counters 0.
//  Request FIFO: push = rel_req_valid&rel_req_ready. Ready does not depend on same-cycle pop.
//   Full: rel_req_ready=0. Request offered while not ready is not captured (upstream holds).
//  FSM (registered state; all outputs registered, decoded from next state):
//   IDLE: FIFO non-empty & freeb_init_done -> pop; cur<=head, tail<=tail, cnt<=0; -> EMIT.
//   EMIT (1 cycle): rel_buf_valid=1, rel_buf_ptr=cur, cnt<=cnt+1.
//    cur==tail -> rel_done=1, rel_done_count=cnt+1 in the cycle after EMIT; -> IDLE.
//    else if cnt+1 == 2**PTR_NBITS -> rel_err=1, rel_done_count=cnt+1; -> IDLE (no ll_rd).
//    else ll_rd=1, ll_rd_ptr=cur in the same cycle; -> WAIT with lat_cnt=LL_RD_LAT-1.
//   WAIT: decrement lat_cnt; when ll_rd_data arrives: cur<=ll_rd_data -> EMIT.
//  Throughput: one buffer per (1+LL_RD_LAT) cycles inside a chain.
//  Latency: pop in IDLE at cycle t -> rel_buf_valid at t+1. Back-to-back chains:
//   rel_done cycle is IDLE; next pop is then, so the next EMIT is 2 cycles after the last EMIT.
//  rel_buf_valid never asserted while freeb_init_done=0.
//  freeb_init_done low in any state: next edge FSM -> IDLE, request FIFO flushed, walk dropped.
//   No rel_done/rel_err for the dropped chain. ll_rd_data still in flight is ignored.
//  Reset mid-walk: same as above; outputs 0 the cycle after reset is sampled.
//  Pointers wrap naturally at PTR_NBITS; no arithmetic on pointers, compare only.
//  cnt is PTR_NBITS+1 bits wide, so 2**PTR_NBITS is representable.
// TESTING
//  1-buffer pkt head=tail=5 -> single rel_buf_valid ptr=5 one cycle after pop; rel_done, count=1;
//   no ll_rd.
//  Chain 3->7->9 (tail 9), LL_RD_LAT=2 -> rel_buf_ptr 3,7,9 at cycles t+1,t+4,t+7;
//   ll_rd_ptr 3,7; rel_done, count=3.
//  Push 5 requests back-to-back with REQ_DEPTH=4 and FSM busy -> 5th held (ready=0) until first pop;
//   all 5 chains released in order.
//  Corrupt link (ll_rd_data always = self, tail unreachable), PTR_NBITS=4 -> exactly 16
//   rel_buf_valid, then rel_err, count=16; FSM IDLE.
//  Drop freeb_init_done during WAIT of 2nd buffer with 2 requests queued -> no further
//   rel_buf_valid; FIFO empty; busy=0 next cycle; ready low until done=1.
//  Assert reset mid-chain -> all outputs 0 next cycle; a new request after reset is walked from
//   its head correctly.

Source files
------------

// File: rtl/bm_buf_release.sv
// Buffer release walker: pops release requests (head/tail pointer pairs) from
// a small FIFO and walks each chain through link memory. Every buffer on the
// chain is handed to free buffer control as one rel_buf_valid pulse. One chain
// is walked at a time. A chain that has not reached its tail after
// 2**PTR_NBITS buffers is aborted with rel_err.
//
// Handshake: a request is transferred on a rising clk edge where
// rel_req_valid and rel_req_ready are both 1. rel_req_ready depends only on
// FIFO fullness, freeb_init_done and reset, never on a same-cycle pop. While
// ready is low the upstream holds its request. There is no backpressure on
// rel_buf_valid, rel_done or rel_err.
module bm_buf_release #(
   parameter int PTR_NBITS = 4,
   parameter int LL_RD_LAT = 2,
   parameter int REQ_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 freeb_init_done,
   input  logic                 rel_req_valid,
   input  logic [PTR_NBITS-1:0] rel_req_head_ptr,
   input  logic [PTR_NBITS-1:0] rel_req_tail_ptr,
   output logic                 rel_req_ready,
   output logic                 ll_rd,
   output logic [PTR_NBITS-1:0] ll_rd_ptr,
   input  logic [PTR_NBITS-1:0] ll_rd_data,
   output logic                 rel_buf_valid,
   output logic [PTR_NBITS-1:0] rel_buf_ptr,
   output logic                 rel_done,
   output logic [PTR_NBITS:0]   rel_done_count,
   output logic                 rel_err,
   output logic                 busy,
   output logic [1:0]           dbg_state
);

   localparam int AW   = (REQ_DEPTH > 1) ? $clog2(REQ_DEPTH) : 1;
   localparam int LW   = (LL_RD_LAT > 1) ? $clog2(LL_RD_LAT) : 1;
   localparam int CW   = PTR_NBITS + 1;
   localparam logic [CW-1:0] FULL_CNT = {1'b1, {PTR_NBITS{1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EMIT = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   // ---------------------------------------------------------------- FIFO
   logic [PTR_NBITS-1:0] fifo_head [REQ_DEPTH];
   logic [PTR_NBITS-1:0] fifo_tail [REQ_DEPTH];
   logic [AW:0]          wr_ptr, rd_ptr;
   logic                 fifo_empty, fifo_full;
   logic                 push, pop;

   assign fifo_empty    = (wr_ptr == rd_ptr);
   assign fifo_full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                          (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign rel_req_ready = !fifo_full && freeb_init_done && !rst;
   assign push          = rel_req_valid && rel_req_ready;

   // Request storage; contents are only meaningful between the pointers.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_head[wr_ptr[AW-1:0]] <= rel_req_head_ptr;
         fifo_tail[wr_ptr[AW-1:0]] <= rel_req_tail_ptr;
      end
   end

   // FIFO pointers; a pool (re)init flushes every queued request.
   always_ff @(posedge clk) begin
      if (rst || !freeb_init_done) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // ----------------------------------------------------------------- FSM
   state_t               state_q, state_d;
   logic [PTR_NBITS-1:0] cur_q, cur_d;
   logic [PTR_NBITS-1:0] tail_q, tail_d;
   logic [CW-1:0]        cnt_q, cnt_d, cnt_inc;
   logic [LW-1:0]        lat_q, lat_d;

   assign cnt_inc   = cnt_q + CW'(1);
   assign busy      = (state_q != S_IDLE) || !fifo_empty;
   assign dbg_state = state_q;

   // State register and walk datapath.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cur_q   <= '0;
         tail_q  <= '0;
         cnt_q   <= '0;
         lat_q   <= '0;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         tail_q  <= tail_d;
         cnt_q   <= cnt_d;
         lat_q   <= lat_d;
      end
   end

   // Next state: pop a chain, emit one buffer, then wait out the link read.
   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      tail_d  = tail_q;
      cnt_d   = cnt_q;
      lat_d   = lat_q;
      pop     = 1'b0;
      if (!freeb_init_done) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  cur_d   = fifo_head[rd_ptr[AW-1:0]];
                  tail_d  = fifo_tail[rd_ptr[AW-1:0]];
                  cnt_d   = '0;
                  state_d = S_EMIT;
               end
            end
            S_EMIT: begin
               cnt_d = cnt_inc;
               if (cur_q == tail_q || cnt_inc == FULL_CNT) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_WAIT;
                  lat_d   = LW'(LL_RD_LAT - 1);
               end
            end
            S_WAIT: begin
               if (lat_q == '0) begin
                  cur_d   = ll_rd_data;
                  state_d = S_EMIT;
               end else begin
                  lat_d = lat_q - LW'(1);
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------- outputs
   logic                 rel_buf_valid_q, rel_buf_valid_d;
   logic [PTR_NBITS-1:0] rel_buf_ptr_d;
   logic                 ll_rd_d;
   logic [PTR_NBITS-1:0] ll_rd_ptr_d;
   logic                 rel_done_d, rel_err_d;
   logic [CW-1:0]        rel_done_count_d;
   logic                 emit_d, finishing;

   // Output decode from the next state, so every output is a flop. The link
   // read for the next pointer is issued alongside the emit unless this
   // buffer is the tail or the last one allowed before the abort.
   always_comb begin
      emit_d           = (state_d == S_EMIT);
      finishing        = freeb_init_done && (state_q == S_EMIT);
      rel_buf_valid_d  = emit_d;
      rel_buf_ptr_d    = emit_d ? cur_d : '0;
      ll_rd_d          = emit_d && (cur_d != tail_d) &&
                         ((cnt_d + CW'(1)) != FULL_CNT);
      ll_rd_ptr_d      = ll_rd_d ? cur_d : '0;
      rel_done_d       = finishing && (cur_q == tail_q);
      rel_err_d        = finishing && (cur_q != tail_q) && (cnt_inc == FULL_CNT);
      rel_done_count_d = (rel_done_d || rel_err_d) ? cnt_inc : '0;
   end

   // Output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         rel_buf_valid_q <= 1'b0;
         rel_buf_ptr     <= '0;
         ll_rd           <= 1'b0;
         ll_rd_ptr       <= '0;
         rel_done        <= 1'b0;
         rel_err         <= 1'b0;
         rel_done_count  <= '0;
      end else begin
         rel_buf_valid_q <= rel_buf_valid_d;
         rel_buf_ptr     <= rel_buf_ptr_d;
         ll_rd           <= ll_rd_d;
         ll_rd_ptr       <= ll_rd_ptr_d;
         rel_done        <= rel_done_d;
         rel_err         <= rel_err_d;
         rel_done_count  <= rel_done_count_d;
      end
   end

   // A release must never reach the free pool while it is being rebuilt, even
   // in the first cycle freeb_init_done drops.
   assign rel_buf_valid = rel_buf_valid_q && freeb_init_done;

endmodule

// File: tb/tb_bm_buf_release.sv
// Directed bench for bm_buf_release: chain table plus hand-written sequences
// for queue backpressure, corrupt links, pool re-init and mid-walk reset.
module tb_bm_buf_release;

   localparam int PW    = 4;
   localparam int LAT   = 2;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          freeb_init_done = 1'b0;
   logic          rel_req_valid = 1'b0;
   logic [PW-1:0] rel_req_head_ptr = '0;
   logic [PW-1:0] rel_req_tail_ptr = '0;
   logic          rel_req_ready;
   logic          ll_rd;
   logic [PW-1:0] ll_rd_ptr;
   logic [PW-1:0] ll_rd_data;
   logic          rel_buf_valid;
   logic [PW-1:0] rel_buf_ptr;
   logic          rel_done;
   logic [PW:0]   rel_done_count;
   logic          rel_err;
   logic          busy;
   logic [1:0]    dbg_state;

   bm_buf_release #(.PTR_NBITS(PW), .LL_RD_LAT(LAT), .REQ_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .freeb_init_done(freeb_init_done),
      .rel_req_valid(rel_req_valid), .rel_req_head_ptr(rel_req_head_ptr),
      .rel_req_tail_ptr(rel_req_tail_ptr), .rel_req_ready(rel_req_ready),
      .ll_rd(ll_rd), .ll_rd_ptr(ll_rd_ptr), .ll_rd_data(ll_rd_data),
      .rel_buf_valid(rel_buf_valid), .rel_buf_ptr(rel_buf_ptr),
      .rel_done(rel_done), .rel_done_count(rel_done_count), .rel_err(rel_err),
      .busy(busy), .dbg_state(dbg_state)
   );

   // ------------------------------------------------ clock / cycle counter
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ------------------------------------- link memory, 2-cycle read model
   logic [PW-1:0] link_mem [16];
   logic [PW-1:0] rd_p1 = '0, rd_p2 = '0;
   always @(posedge clk) begin
      rd_p1 <= ll_rd ? link_mem[ll_rd_ptr] : '0;
      rd_p2 <= rd_p1;
   end
   assign ll_rd_data = rd_p2;

   // ------------------------------------------------------- check counters
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // ---------------------------------------------------- output monitor
   logic [PW-1:0] got_ptr_q[$];
   int            got_cyc_q[$];
   logic [PW-1:0] got_rd_q[$];
   int            got_rdc_q[$];
   logic [PW:0]   got_done_q[$];
   int            got_donec_q[$];
   logic [PW:0]   got_err_q[$];

   always @(negedge clk) begin
      if (rel_buf_valid) begin
         got_ptr_q.push_back(rel_buf_ptr);
         got_cyc_q.push_back(cyc);
         check("valid_while_init_low", {31'd0, freeb_init_done}, 32'd1);
      end
      if (ll_rd) begin
         got_rd_q.push_back(ll_rd_ptr);
         got_rdc_q.push_back(cyc);
      end
      if (rel_done) begin
         got_done_q.push_back(rel_done_count);
         got_donec_q.push_back(cyc);
      end
      if (rel_err) got_err_q.push_back(rel_done_count);
   end

   // ----------------------------------------------------------- scoreboard
   logic [PW-1:0] exp_q[$];
   int            exp_cyc_q[$];
   logic [PW-1:0] exp_rd_q[$];
   int            exp_rdc_q[$];
   logic [PW:0]   exp_done_q[$];
   int            exp_donec_q[$];
   logic [PW:0]   exp_err_q[$];

   task automatic clear_q();
      got_ptr_q.delete(); got_cyc_q.delete(); got_rd_q.delete(); got_rdc_q.delete();
      got_done_q.delete(); got_donec_q.delete(); got_err_q.delete();
      exp_q.delete(); exp_cyc_q.delete(); exp_rd_q.delete(); exp_rdc_q.delete();
      exp_done_q.delete(); exp_donec_q.delete(); exp_err_q.delete();
   endtask

   task automatic score(input string tag);
      check({tag, " emit_n"}, got_ptr_q.size(), exp_q.size());
      while (exp_q.size() > 0 && got_ptr_q.size() > 0) begin
         check({tag, " emit_ptr"}, {28'd0, got_ptr_q.pop_front()}, {28'd0, exp_q.pop_front()});
         check({tag, " emit_cyc"}, got_cyc_q.pop_front(), exp_cyc_q.pop_front());
      end
      check({tag, " rd_n"}, got_rd_q.size(), exp_rd_q.size());
      while (exp_rd_q.size() > 0 && got_rd_q.size() > 0) begin
         check({tag, " rd_ptr"}, {28'd0, got_rd_q.pop_front()}, {28'd0, exp_rd_q.pop_front()});
         check({tag, " rd_cyc"}, got_rdc_q.pop_front(), exp_rdc_q.pop_front());
      end
      check({tag, " done_n"}, got_done_q.size(), exp_done_q.size());
      while (exp_done_q.size() > 0 && got_done_q.size() > 0) begin
         check({tag, " done_count"}, {27'd0, got_done_q.pop_front()}, {27'd0, exp_done_q.pop_front()});
         check({tag, " done_cyc"}, got_donec_q.pop_front(), exp_donec_q.pop_front());
      end
      check({tag, " err_n"}, got_err_q.size(), exp_err_q.size());
      while (exp_err_q.size() > 0 && got_err_q.size() > 0)
         check({tag, " err_count"}, {27'd0, got_err_q.pop_front()}, {27'd0, exp_err_q.pop_front()});
      clear_q();
   endtask

   // ------------------------------------------------------ vector table
   typedef struct {
      logic [PW-1:0] head;
      logic [PW-1:0] tail;
      int            cnt;
      logic [PW-1:0] ptr [4];
   } vec_t;

   vec_t vec [7];

   task automatic set_vec(input int i, input logic [PW-1:0] h, input logic [PW-1:0] t,
                          input int c, input logic [PW-1:0] a, input logic [PW-1:0] b,
                          input logic [PW-1:0] d, input logic [PW-1:0] e);
      vec[i].head = h; vec[i].tail = t; vec[i].cnt = c;
      vec[i].ptr[0] = a; vec[i].ptr[1] = b; vec[i].ptr[2] = d; vec[i].ptr[3] = e;
   endtask

   // Expected traffic for table chain i whose first emit lands on cycle first.
   task automatic add_chain(input int i, input int first, output int last);
      for (int k = 0; k < vec[i].cnt; k++) begin
         exp_q.push_back(vec[i].ptr[k]);
         exp_cyc_q.push_back(first + 3 * k);
         if (k < vec[i].cnt - 1) begin
            exp_rd_q.push_back(vec[i].ptr[k]);
            exp_rdc_q.push_back(first + 3 * k);
         end
      end
      last = first + 3 * (vec[i].cnt - 1);
      exp_done_q.push_back((PW+1)'(vec[i].cnt));
      exp_donec_q.push_back(last + 1);
   endtask

   // ------------------------------------------------------- driver tasks
   task automatic send_req(input logic [PW-1:0] h, input logic [PW-1:0] t,
                           output int push_cyc, output int waits);
      waits = 0;
      @(negedge clk);
      rel_req_valid    = 1'b1;
      rel_req_head_ptr = h;
      rel_req_tail_ptr = t;
      while (!rel_req_ready && waits < 200) begin
         @(negedge clk);
         waits++;
      end
      if (waits >= 200) check("req_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      push_cyc      = cyc;
      rel_req_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      @(negedge clk); #1;
      while (busy && n < 400) begin
         @(negedge clk); #1;
         n++;
      end
      if (n >= 400) check({tag, " idle_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic wait_emits(input int num);
      int n = 0;
      while (got_ptr_q.size() < num && n < 200) begin
         @(negedge clk); #1;
         n++;
      end
      if (n >= 200) check("emit_timeout", 32'd0, 32'd1);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " rel_buf_valid"}, {31'd0, rel_buf_valid}, 32'd0);
      check({tag, " rel_buf_ptr"}, {28'd0, rel_buf_ptr}, 32'd0);
      check({tag, " ll_rd"}, {31'd0, ll_rd}, 32'd0);
      check({tag, " ll_rd_ptr"}, {28'd0, ll_rd_ptr}, 32'd0);
      check({tag, " rel_done"}, {31'd0, rel_done}, 32'd0);
      check({tag, " rel_err"}, {31'd0, rel_err}, 32'd0);
      check({tag, " rel_done_count"}, {27'd0, rel_done_count}, 32'd0);
      check({tag, " busy"}, {31'd0, busy}, 32'd0);
      check({tag, " ready"}, {31'd0, rel_req_ready}, 32'd0);
      check({tag, " state"}, {30'd0, dbg_state}, 32'd0);
   endtask

   task automatic run_single(input int i);
      int p, w, last;
      send_req(vec[i].head, vec[i].tail, p, w);
      add_chain(i, p + 1, last);
      wait_idle($sformatf("vec%0d", i));
      repeat (2) @(negedge clk);
      score($sformatf("vec%0d", i));
   endtask

   // ------------------------------------------------------------ the test
   initial begin
      int p, w, last;
      int seq [5];

      for (int i = 0; i < 16; i++) link_mem[i] = '0;
      link_mem[3]  = 4'd7;  link_mem[7]  = 4'd9;
      link_mem[1]  = 4'd2;  link_mem[2]  = 4'd4;  link_mem[4] = 4'd8;
      link_mem[10] = 4'd11; link_mem[11] = 4'd0;  link_mem[0] = 4'd15;
      link_mem[15] = 4'd14; link_mem[12] = 4'd6;  link_mem[6] = 4'd13;
      link_mem[5]  = 4'd5;

      set_vec(0, 4'd5,  4'd5,  1, 4'd5,  4'd0,  4'd0,  4'd0);
      set_vec(1, 4'd3,  4'd9,  3, 4'd3,  4'd7,  4'd9,  4'd0);
      set_vec(2, 4'd1,  4'd8,  4, 4'd1,  4'd2,  4'd4,  4'd8);
      set_vec(3, 4'd10, 4'd15, 4, 4'd10, 4'd11, 4'd0,  4'd15);
      set_vec(4, 4'd12, 4'd13, 3, 4'd12, 4'd6,  4'd13, 4'd0);
      set_vec(5, 4'd15, 4'd14, 2, 4'd15, 4'd14, 4'd0,  4'd0);
      set_vec(6, 4'd9,  4'd9,  1, 4'd9,  4'd0,  4'd0,  4'd0);

      // Reset state, with the pool already reporting ready.
      rst = 1'b1;
      freeb_init_done = 1'b1;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      freeb_init_done = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      check("ready_init_low", {31'd0, rel_req_ready}, 32'd0);
      freeb_init_done = 1'b1;
      @(negedge clk);
      check("ready_init_high", {31'd0, rel_req_ready}, 32'd1);
      clear_q();

      // Table of single chains, each walked in isolation.
      for (int i = 0; i < 7; i++) run_single(i);

      // Busy FSM, then five back-to-back requests: the fifth must stall.
      seq = '{1, 3, 4, 5, 6};
      send_req(vec[2].head, vec[2].tail, p, w);
      add_chain(2, p + 1, last);
      for (int k = 0; k < 5; k++) begin
         send_req(vec[seq[k]].head, vec[seq[k]].tail, p, w);
         if (k == 4) check("fifth_req_held", {31'd0, (w > 0)}, 32'd1);
         else        check("req_not_held", w, 32'd0);
      end
      for (int k = 0; k < 5; k++) add_chain(seq[k], last + 2, last);
      wait_idle("b2b");
      repeat (2) @(negedge clk);
      score("b2b");

      // Corrupt link: buffer 5 points at itself and tail 9 is unreachable.
      send_req(4'd5, 4'd9, p, w);
      for (int k = 0; k < 16; k++) begin
         exp_q.push_back(4'd5);
         exp_cyc_q.push_back(p + 1 + 3 * k);
         if (k < 15) begin
            exp_rd_q.push_back(4'd5);
            exp_rdc_q.push_back(p + 1 + 3 * k);
         end
      end
      exp_err_q.push_back(5'd16);
      wait_idle("corrupt");
      check("corrupt_state_idle", {30'd0, dbg_state}, 32'd0);
      repeat (2) @(negedge clk);
      score("corrupt");

      // Pool re-init during the wait after the second buffer, two chains queued.
      send_req(vec[2].head, vec[2].tail, p, w);
      exp_q.push_back(4'd1);  exp_cyc_q.push_back(p + 1);
      exp_q.push_back(4'd2);  exp_cyc_q.push_back(p + 4);
      exp_rd_q.push_back(4'd1); exp_rdc_q.push_back(p + 1);
      exp_rd_q.push_back(4'd2); exp_rdc_q.push_back(p + 4);
      send_req(vec[1].head, vec[1].tail, p, w);
      send_req(vec[0].head, vec[0].tail, p, w);
      wait_emits(2);
      @(negedge clk);
      freeb_init_done = 1'b0;
      @(negedge clk); #1;
      check("drop busy", {31'd0, busy}, 32'd0);
      check("drop ready", {31'd0, rel_req_ready}, 32'd0);
      check("drop state", {30'd0, dbg_state}, 32'd0);
      check("drop valid", {31'd0, rel_buf_valid}, 32'd0);
      repeat (8) @(negedge clk);
      #1;
      check("drop ready_still_low", {31'd0, rel_req_ready}, 32'd0);
      freeb_init_done = 1'b1;
      @(negedge clk); #1;
      check("reinit ready", {31'd0, rel_req_ready}, 32'd1);
      check("reinit busy", {31'd0, busy}, 32'd0);
      repeat (6) @(negedge clk);
      score("drop");

      // Reset in the middle of a chain, then a fresh chain walks cleanly.
      send_req(vec[2].head, vec[2].tail, p, w);
      wait_emits(2);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk); #1;
      check_all_zero("midreset");
      rst = 1'b0;
      repeat (4) @(negedge clk);
      clear_q();
      run_single(1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Hard stop in case a wait somewhere escapes its own bound.
   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "global timeout");
   end

endmodule
